mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester round-robin arbiter sharing the single-port on-chip program/data memory (MEM_SIZE 32-bit words) between the picorv32 core (requester 0) and a second bus master such as an accelerometer-sample DMA (requester 1). Both requesters use the picorv32 native valid/ready handshake. The arbiter serialises their accesses onto one synchronous-read memory port, with a fixed 3-cycle transaction, and completes out-of-range accesses locally with an error pulse.

## Interface
- MEM_SIZE, 4096: memory depth in 32-bit words; must be a power of two.
- AW, 12: word-address width; equals log2(MEM_SIZE).
- clk  input  1  system clock; all logic on rising edge.
- resetn  input  1  reset, asynchronous, active-low.
- r0_valid, r1_valid  input  1 each  request valid; held with addr/wdata/wstrb stable until the matching ready.
- r0_addr, r1_addr  input  32 each  byte address; bits [1:0] ignored.
- r0_wdata, r1_wdata  input  32 each  write data.
- r0_wstrb, r1_wstrb  input  4 each  byte write strobes; 0 means read.
- r0_ready, r1_ready  output  1 each  one-cycle completion pulse.
- r0_rdata, r1_rdata  output  32 each  read data, valid only while the matching ready is 1.
- mem_en  output  1  memory access enable.
- mem_we  output  4  byte write enables; qualified by mem_en.
- mem_addr  output  AW  word address.
- mem_wdata  output  32  write data.
- mem_rdata  input  32  memory read data; registered, available one cycle after mem_en.
- grant  output  2  one-hot current owner; 2'b00 when idle.
- oob_err  output  1  one-cycle pulse when an out-of-range access completes.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No valid asserted: stay in IDLE.
  - Exactly one valid asserted: latch that requester into owner; go to ACCESS.
  - Both valid asserted: grant the requester that is not last_grant; go to ACCESS.
  - last_grant is updated to the granted index at every grant.
- ACCESS:
  - In range ((addr>>2) < MEM_SIZE): mem_en=1; mem_we=owner wstrb; mem_addr=owner addr[AW+1:2]; mem_wdata=owner wdata.
  - Out of range: mem_en=0; mem_we=0; oob flag latched.
  - Always go to RESP.
- RESP:
  - Owner's ready=1.
  - Owner's rdata = mem_rdata for an in-range read; 0 for a write or any out-of-range access.
  - oob_err=1 if the oob flag is set.
  - Go to IDLE.
- Non-owner ready is always 0. Both rdata outputs are 0 whenever their ready is 0.
- grant reflects owner during ACCESS and RESP; 0 in IDLE.
- mem_we is 0 whenever mem_en is 0. mem_addr and mem_wdata hold their last values when idle.
- A valid asserted while the other requester owns the port waits. It is considered at the next IDLE.
- Strict alternation under continuous contention; neither requester waits more than one transaction.

## Timing
- Reset (asynchronous, any state, mid-transaction included):
  - state=IDLE; last_grant=1, so requester 0 wins the first tie.
  - All ready, mem_en, mem_we, grant and oob_err are 0; all rdata are 0.
  - An in-flight transaction is abandoned; no ready is issued for it.
- Valid sampled in IDLE at edge N: ACCESS during cycle N+1, RESP during cycle N+2, ready high for exactly cycle N+2.
- Latency from valid to ready: 2 cycles, uncontended.
- Throughput: one transaction per 3 cycles.
- Contention: the losing requester's ready arrives 3 cycles after the winner's.
- A requester may drop valid in the cycle after ready. If it keeps valid high, that is a new request, arbitrated in IDLE.
- Valid deasserted by a requester before its ready violates protocol; the arbiter still completes the latched transaction.
- A write is committed at the end of ACCESS; a read by the other requester in the next transaction sees the new data.

## Test plan
- Single read: preload word 5 = 32'hDEADBEEF; r0 reads addr 32'h14 -> r0_ready pulses 2 cycles after valid, r0_rdata=32'hDEADBEEF, grant=2'b01 during ACCESS and RESP, r1_ready never asserts.
- Write then read: r1 writes 32'hA5A5A5A5 with wstrb 4'b0011 to addr 32'h40 holding 0 -> mem_we=4'b0011; a following r0 read of 32'h40 returns 32'h0000A5A5.
- Contention: both valid from reset, held high -> grants go r0, r1, r0, r1; readies are 3 cycles apart; no requester is granted twice in a row.
- Out of range: r0 reads addr 32'h0000_4000 (MEM_SIZE 4096) -> mem_en stays 0, r0_rdata=0, oob_err and r0_ready pulse together in the same cycle.
- Reset mid-op: assert resetn=0 asynchronously during ACCESS -> all outputs are 0 immediately, no ready is issued; after release, simultaneous requests grant r0 first.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of both requester handshakes (picorv32 native
// valid/ready) and the single-port synchronous-read memory port.
//   slave  modport : the arbiter (consumes requests, drives the memory port)
//   master modport : requesters + memory model (drive requests, mem_rdata)
// AW is the memory word-address width.
interface mem_arbiter_if #(
    parameter int AW = 12
);
    logic        r0_valid;
    logic [31:0] r0_addr;
    logic [31:0] r0_wdata;
    logic [3:0]  r0_wstrb;
    logic        r0_ready;
    logic [31:0] r0_rdata;

    logic        r1_valid;
    logic [31:0] r1_addr;
    logic [31:0] r1_wdata;
    logic [3:0]  r1_wstrb;
    logic        r1_ready;
    logic [31:0] r1_rdata;

    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    logic [1:0]  grant;
    logic        oob_err;

    modport slave (
        input  r0_valid, r0_addr, r0_wdata, r0_wstrb,
        input  r1_valid, r1_addr, r1_wdata, r1_wstrb,
        input  mem_rdata,
        output r0_ready, r0_rdata, r1_ready, r1_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output grant, oob_err
    );

    modport master (
        output r0_valid, r0_addr, r0_wdata, r0_wstrb,
        output r1_valid, r1_addr, r1_wdata, r1_wstrb,
        output mem_rdata,
        input  r0_ready, r0_rdata, r1_ready, r1_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  grant, oob_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter onto one synchronous-read
// memory port. Each transaction takes IDLE -> ACCESS -> RESP (3 cycles);
// out-of-range accesses skip the memory and complete with an oob_err pulse.
//   clk    : system clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : requester handshakes, memory port, grant and oob_err
module mem_arbiter #(
    parameter int MEM_SIZE = 4096,
    parameter int AW       = 12
) (
    input  logic               clk,
    input  logic               resetn,
    mem_arbiter_if.slave       bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t        state, state_next;
    logic          owner;
    logic          last_grant;
    logic          oob;
    logic [3:0]    wstrb_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;

    logic          req_any;
    logic          sel;
    logic [31:0]   sel_addr;
    logic [31:0]   sel_wdata;
    logic [3:0]    sel_wstrb;
    logic          sel_oob;
    logic [31:0]   resp_data;

    // Tie goes to whichever requester was not granted last.
    always_comb begin
        req_any = bus.r0_valid | bus.r1_valid;
        if (bus.r0_valid && bus.r1_valid) sel = ~last_grant;
        else                              sel = bus.r1_valid;
        sel_addr  = sel ? bus.r1_addr  : bus.r0_addr;
        sel_wdata = sel ? bus.r1_wdata : bus.r0_wdata;
        sel_wstrb = sel ? bus.r1_wstrb : bus.r0_wstrb;
        sel_oob   = (sel_addr >> 2) >= 32'(MEM_SIZE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    // Request fields are captured at grant so a requester that drops valid
    // early cannot corrupt the transaction already in flight. The memory
    // address/data registers only load for in-range accesses, so they hold
    // their last values otherwise.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner      <= 1'b0;
            last_grant <= 1'b1;
            oob        <= 1'b0;
            wstrb_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else if (state == IDLE && req_any) begin
            owner      <= sel;
            last_grant <= sel;
            oob        <= sel_oob;
            wstrb_q    <= sel_wstrb;
            if (!sel_oob) begin
                addr_q  <= sel_addr[AW+1:2];
                wdata_q <= sel_wdata;
            end
        end
    end

    always_comb begin
        state_next    = state;
        bus.mem_en    = 1'b0;
        bus.mem_we    = '0;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.grant     = '0;
        bus.oob_err   = 1'b0;
        bus.r0_ready  = 1'b0;
        bus.r1_ready  = 1'b0;
        bus.r0_rdata  = '0;
        bus.r1_rdata  = '0;
        resp_data     = (!oob && wstrb_q == 4'b0000) ? bus.mem_rdata : '0;

        case (state)
            IDLE: begin
                if (req_any) state_next = ACCESS;
            end
            ACCESS: begin
                bus.grant  = owner ? 2'b10 : 2'b01;
                bus.mem_en = ~oob;
                bus.mem_we = oob ? 4'b0000 : wstrb_q;
                state_next = RESP;
            end
            RESP: begin
                bus.grant   = owner ? 2'b10 : 2'b01;
                bus.oob_err = oob;
                if (owner) begin
                    bus.r1_ready = 1'b1;
                    bus.r1_rdata = resp_data;
                end else begin
                    bus.r0_ready = 1'b1;
                    bus.r0_rdata = resp_data;
                end
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a behavioural
// synchronous-read memory (read-before-write) and a backdoor preload port.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(12)) bus();

    mem_arbiter #(.MEM_SIZE(4096), .AW(12)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    logic [31:0] mem [0:4095];
    logic        pl_en = 1'b0;
    logic [11:0] pl_addr = '0;
    logic [31:0] pl_data = '0;

    initial bus.mem_rdata = '0;

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (bus.mem_en) begin
            for (int b = 0; b < 4; b++)
                if (bus.mem_we[b]) mem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        logic        exp_oob;
    } vec_t;

    vec_t vecs[12];

    task automatic drive(input logic req, input logic valid, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
        if (req) begin
            bus.r1_valid = valid; bus.r1_addr = addr; bus.r1_wdata = wdata; bus.r1_wstrb = wstrb;
        end else begin
            bus.r0_valid = valid; bus.r0_addr = addr; bus.r0_wdata = wdata; bus.r0_wstrb = wstrb;
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"},   32'(bus.grant), 32'h0);
        chk({tag, "_mem_en"},  32'(bus.mem_en), 32'h0);
        chk({tag, "_mem_we"},  32'(bus.mem_we), 32'h0);
        chk({tag, "_r0_ready"}, 32'(bus.r0_ready), 32'h0);
        chk({tag, "_r1_ready"}, 32'(bus.r1_ready), 32'h0);
        chk({tag, "_oob_err"}, 32'(bus.oob_err), 32'h0);
        chk({tag, "_r0_rdata"}, bus.r0_rdata, 32'h0);
        chk({tag, "_r1_rdata"}, bus.r1_rdata, 32'h0);
    endtask

    // Called at a negedge with the arbiter idle; leaves it idle again.
    task automatic run_vec(input vec_t v);
        logic got;
        int   cyc;
        logic rdy;
        got = 1'b0;
        cyc = 0;
        drive(v.req, 1'b1, v.addr, v.wdata, v.wstrb);
        for (int c = 1; c <= 6 && !got; c++) begin
            @(negedge clk);
            cyc = c;
            if (c == 1) begin
                chk("access_grant", 32'(bus.grant), v.req ? 32'h2 : 32'h1);
                chk("access_mem_en", 32'(bus.mem_en), 32'(!v.exp_oob));
                chk("access_mem_we", 32'(bus.mem_we), v.exp_oob ? 32'h0 : 32'(v.wstrb));
                if (!v.exp_oob) chk("access_mem_addr", 32'(bus.mem_addr), 32'(v.addr[13:2]));
                if (!v.exp_oob && v.wstrb != 4'b0) chk("access_mem_wdata", bus.mem_wdata, v.wdata);
            end
            rdy = v.req ? bus.r1_ready : bus.r0_ready;
            if (rdy) got = 1'b1;
        end
        chk("ready_latency", got ? 32'(cyc) : 32'hFFFF_FFFF, 32'd2);
        if (got) begin
            chk("resp_rdata", v.req ? bus.r1_rdata : bus.r0_rdata, v.exp_rdata);
            chk("resp_oob_err", 32'(bus.oob_err), 32'(v.exp_oob));
            chk("resp_grant", 32'(bus.grant), v.req ? 32'h2 : 32'h1);
            chk("resp_other_ready", 32'(v.req ? bus.r0_ready : bus.r1_ready), 32'h0);
            chk("resp_other_rdata", v.req ? bus.r0_rdata : bus.r1_rdata, 32'h0);
        end
        drive(v.req, 1'b0, v.addr, v.wdata, v.wstrb);
        @(negedge clk);
        chk_all_zero("idle");
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        //            req   addr           wdata          wstrb  rdata          oob
        vecs[0]  = '{1'b0, 32'h0000_0014, 32'h0,         4'h0,  32'hDEADBEEF, 1'b0};
        vecs[1]  = '{1'b1, 32'h0000_0040, 32'hA5A5A5A5, 4'h3,  32'h0,        1'b0};
        vecs[2]  = '{1'b0, 32'h0000_0040, 32'h0,         4'h0,  32'h0000A5A5, 1'b0};
        vecs[3]  = '{1'b1, 32'h0000_0040, 32'h0,         4'h0,  32'h0000A5A5, 1'b0};
        vecs[4]  = '{1'b0, 32'h0000_0040, 32'h12345678, 4'hC,  32'h0,        1'b0};
        vecs[5]  = '{1'b1, 32'h0000_0040, 32'h0,         4'h0,  32'h1234A5A5, 1'b0};
        vecs[6]  = '{1'b0, 32'h0000_4000, 32'h0,         4'h0,  32'h0,        1'b1};
        vecs[7]  = '{1'b1, 32'h0000_3FFC, 32'hFFFFFFFF, 4'hF,  32'h0,        1'b0};
        vecs[8]  = '{1'b1, 32'h0000_3FFC, 32'h0,         4'h0,  32'hFFFFFFFF, 1'b0};
        vecs[9]  = '{1'b0, 32'h4000_0000, 32'h0,         4'h0,  32'h0,        1'b1};
        vecs[10] = '{1'b1, 32'h0000_4000, 32'h11111111, 4'hF,  32'h0,        1'b1};
        vecs[11] = '{1'b0, 32'h0000_3FFF, 32'h0,         4'h0,  32'hFFFFFFFF, 1'b0};

        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        preload(12'd5, 32'hDEADBEEF);
        preload(12'd16, 32'h0);
        preload(12'd4095, 32'h0);
        chk_all_zero("reset");
        @(negedge clk);
        resetn = 1'b1;

        // Continuous contention from reset: r0, r1, r0, r1 with readies 3 apart.
        drive(1'b0, 1'b1, 32'h14, 32'h0, 4'h0);
        drive(1'b1, 1'b1, 32'h14, 32'h0, 4'h0);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            chk($sformatf("cont_r0_ready_c%0d", c), 32'(bus.r0_ready), 32'(c == 2 || c == 8));
            chk($sformatf("cont_r1_ready_c%0d", c), 32'(bus.r1_ready), 32'(c == 5 || c == 11));
            if (c == 1 || c == 7) chk($sformatf("cont_grant_c%0d", c), 32'(bus.grant), 32'h1);
            if (c == 4 || c == 10) chk($sformatf("cont_grant_c%0d", c), 32'(bus.grant), 32'h2);
            if (c == 2) chk("cont_r0_rdata", bus.r0_rdata, 32'hDEADBEEF);
            if (c == 5) chk("cont_r1_rdata", bus.r1_rdata, 32'hDEADBEEF);
            if (c == 11) begin
                drive(1'b0, 1'b0, 32'h14, 32'h0, 4'h0);
                drive(1'b1, 1'b0, 32'h14, 32'h0, 4'h0);
            end
        end
        chk("cont_end_grant", 32'(bus.grant), 32'h0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset during ACCESS of an r0 read: outputs clear immediately, no ready,
        // and the restored last_grant makes r0 win the next tie.
        drive(1'b0, 1'b1, 32'h14, 32'h0, 4'h0);
        @(posedge clk);
        #2;
        chk("midop_pre_mem_en", 32'(bus.mem_en), 32'h1);
        resetn = 1'b0;
        #1;
        chk_all_zero("midop");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("midop_no_r0_ready", 32'(bus.r0_ready), 32'h0);
        end
        drive(1'b1, 1'b1, 32'h40, 32'h0, 4'h0);
        resetn = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk($sformatf("post_r0_ready_c%0d", c), 32'(bus.r0_ready), 32'(c == 2));
            chk($sformatf("post_r1_ready_c%0d", c), 32'(bus.r1_ready), 32'(c == 5));
            if (c == 1) chk("post_first_grant", 32'(bus.grant), 32'h1);
            if (c == 2) begin
                chk("post_r0_rdata", bus.r0_rdata, 32'hDEADBEEF);
                drive(1'b0, 1'b0, 32'h14, 32'h0, 4'h0);
            end
            if (c == 4) chk("post_second_grant", 32'(bus.grant), 32'h2);
            if (c == 5) begin
                chk("post_r1_rdata", bus.r1_rdata, 32'h1234A5A5);
                drive(1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
            end
        end
        @(negedge clk);
        chk_all_zero("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
